// File: rtl/modmult_pkg.sv
// Shared types for the handshake modular multiplier.
package modmult_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/mod_add.sv
// Combinational (a + b) mod m for a, b < m, using one add and one conditional subtract.
module mod_add #(
    parameter int unsigned Width = 32
) (
    input  logic [Width-1:0] a,
    input  logic [Width-1:0] b,
    input  logic [Width-1:0] m,
    output logic [Width-1:0] sum
);

    logic [Width:0]   raw;
    logic [Width-1:0] diff;

    assign raw  = {1'b0, a} + {1'b0, b};
    // The true result is below m, so modulo-2^Width wraparound in diff is harmless.
    assign diff = raw[Width-1:0] - m;
    assign sum  = (raw >= {1'b0, m}) ? diff : raw[Width-1:0];

endmodule

// File: rtl/modmult_hs.sv
// Radix-2 interleaved modular multiplier/squarer with valid/ready handshakes and abort.
module modmult_hs
    import modmult_pkg::*;
#(
    parameter int unsigned MPWID      = 32,
    parameter int unsigned EARLY_EXIT = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode,
    input  logic [MPWID-1:0] mpand,
    input  logic [MPWID-1:0] mplier,
    input  logic [MPWID-1:0] modulus,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [MPWID-1:0] product,
    output logic             err
);

    localparam int unsigned CntW = $clog2(MPWID + 1);

    state_e           state_q, state_d;
    logic [MPWID-1:0] acc_q, acc_d;
    logic [MPWID-1:0] mc_q, mc_d;
    logic [MPWID-1:0] mp_q, mp_d;
    logic [MPWID-1:0] mod_q, mod_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             err_q, err_d;

    logic [MPWID-1:0] acc_sum;
    logic [MPWID-1:0] mc_dbl;
    logic [MPWID-1:0] eff_mplier;
    logic [MPWID-1:0] mp_shift;
    logic             op_err;
    logic             last_iter;

    mod_add #(.Width(MPWID)) u_acc_add (
        .a   (acc_q),
        .b   (mc_q),
        .m   (mod_q),
        .sum (acc_sum)
    );

    mod_add #(.Width(MPWID)) u_dbl_add (
        .a   (mc_q),
        .b   (mc_q),
        .m   (mod_q),
        .sum (mc_dbl)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        mc_d    = mc_q;
        mp_d    = mp_q;
        mod_d   = mod_q;
        cnt_d   = cnt_q;
        err_d   = err_q;

        eff_mplier = mode ? mpand : mplier;
        op_err     = (modulus < MPWID'(2)) || (mpand >= modulus) ||
                     (!mode && (mplier >= modulus));
        mp_shift   = mp_q >> 1;
        last_iter  = (EARLY_EXIT != 0) ? (mp_shift == '0) : (cnt_q == CntW'(MPWID - 1));

        case (state_q)
            StIdle: begin
                if (in_valid && !abort) begin
                    mod_d = modulus;
                    mc_d  = mpand;
                    mp_d  = eff_mplier;
                    acc_d = '0;
                    cnt_d = '0;
                    err_d = op_err;
                    if (op_err) begin
                        mc_d    = '0;
                        mp_d    = '0;
                        state_d = StDone;
                    end else if ((EARLY_EXIT != 0) && (eff_mplier == '0)) begin
                        state_d = StDone;
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                if (mp_q[0]) begin
                    acc_d = acc_sum;
                end
                mc_d  = mc_dbl;
                mp_d  = mp_shift;
                cnt_d = cnt_q + CntW'(1);
                if (last_iter) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                    err_d   = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase

        // Abort wins over accept, iteration and result handshake alike.
        if (abort) begin
            state_d = StIdle;
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            acc_q   <= '0;
            mc_q    <= '0;
            mp_q    <= '0;
            mod_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            mc_q    <= mc_d;
            mp_q    <= mp_d;
            mod_q   <= mod_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign product   = out_valid ? acc_q : '0;
    assign err       = err_q;

endmodule

// File: tb/tb_modmult_hs.sv
// Directed bench: early-exit and fixed-latency instances checked against hand-computed results.
module tb_modmult_hs;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       in_valid_a = 1'b0;
    logic       in_valid_b = 1'b0;
    logic       mode = 1'b0;
    logic [7:0] mpand = '0;
    logic [7:0] mplier = '0;
    logic [7:0] modulus = '0;
    logic       abort = 1'b0;
    logic       out_ready = 1'b0;

    logic       ready_a, ovalid_a, err_a;
    logic       ready_b, ovalid_b, err_b;
    logic [7:0] prod_a, prod_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    modmult_hs #(.MPWID(8), .EARLY_EXIT(1)) u_dut_ee (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid_a),
        .in_ready  (ready_a),
        .mode      (mode),
        .mpand     (mpand),
        .mplier    (mplier),
        .modulus   (modulus),
        .abort     (abort),
        .out_valid (ovalid_a),
        .out_ready (out_ready),
        .product   (prod_a),
        .err       (err_a)
    );

    modmult_hs #(.MPWID(8), .EARLY_EXIT(0)) u_dut_fix (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid_b),
        .in_ready  (ready_b),
        .mode      (mode),
        .mpand     (mpand),
        .mplier    (mplier),
        .modulus   (modulus),
        .abort     (abort),
        .out_valid (ovalid_b),
        .out_ready (out_ready),
        .product   (prod_b),
        .err       (err_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic ov(input bit sel);
        return sel ? ovalid_b : ovalid_a;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept one operand set, measure latency in cycles after the accept edge, then drain.
    task automatic run_op(input bit sel, input logic md, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] m, input logic [7:0] exp_prod, input logic exp_err,
                          input int exp_lat, input string tag);
        int lat;
        mode    = md;
        mpand   = a;
        mplier  = b;
        modulus = m;
        if (sel) in_valid_b = 1'b1;
        else in_valid_a = 1'b1;
        step();
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
        mpand   = ~a;
        mplier  = ~b;
        modulus = 8'd3;
        lat = 1;
        while (!ov(sel) && lat < 100) begin
            step();
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_prod"}, 32'(sel ? prod_b : prod_a), 32'(exp_prod));
        check({tag, "_err"}, 32'(sel ? err_b : err_a), 32'(exp_err));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_ovalid_clr"}, 32'(ov(sel)), 32'd0);
        check({tag, "_err_clr"}, 32'(sel ? err_b : err_a), 32'd0);
    endtask

    initial begin
        int  lat;
        bit  seen;

        #22;
        check("rst_in_ready", 32'(ready_a), 32'd1);
        check("rst_out_valid", 32'(ovalid_a), 32'd0);
        check("rst_product", 32'(prod_a), 32'd0);
        check("rst_err", 32'(err_a), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        run_op(0, 1'b0, 8'd7, 8'd9, 8'd13, 8'd11, 1'b0, 5, "mul7x9");
        run_op(0, 1'b1, 8'd12, 8'd0, 8'd13, 8'd1, 1'b0, 5, "sq12_ee1");
        run_op(1, 1'b1, 8'd12, 8'd0, 8'd13, 8'd1, 1'b0, 9, "sq12_fixed");
        run_op(0, 1'b0, 8'd254, 8'd253, 8'd255, 8'd2, 1'b0, 9, "max_carry");
        run_op(0, 1'b0, 8'd5, 8'd0, 8'd13, 8'd0, 1'b0, 1, "zero_mplier");
        run_op(0, 1'b0, 8'd13, 8'd1, 8'd13, 8'd0, 1'b1, 1, "err_mpand");
        run_op(0, 1'b0, 8'd0, 8'd0, 8'd1, 8'd0, 1'b1, 1, "err_mod1");

        // Backpressure: result held while out_ready low, new accept only after handshake.
        mode = 1'b0; mpand = 8'd3; mplier = 8'd4; modulus = 8'd13;
        in_valid_a = 1'b1;
        step();
        in_valid_a = 1'b0;
        lat = 1;
        while (!ovalid_a && lat < 100) begin
            step();
            lat++;
        end
        check("bp_lat", 32'(lat), 32'd4);
        for (int i = 0; i < 3; i++) begin
            check("bp_hold_valid", 32'(ovalid_a), 32'd1);
            check("bp_hold_prod", 32'(prod_a), 32'd12);
            step();
        end
        mpand = 8'd2; mplier = 8'd3; modulus = 8'd7;
        in_valid_a = 1'b1;
        out_ready  = 1'b1;
        step();
        out_ready = 1'b0;
        check("hs_no_valid", 32'(ovalid_a), 32'd0);
        check("hs_no_accept", 32'(ready_a), 32'd1);
        step();
        in_valid_a = 1'b0;
        check("hs_accept_next", 32'(ready_a), 32'd0);
        lat = 1;
        while (!ovalid_a && lat < 100) begin
            step();
            lat++;
        end
        check("hs2_lat", 32'(lat), 32'd3);
        check("hs2_prod", 32'(prod_a), 32'd6);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Abort in the second cycle of RUN.
        mode = 1'b0; mpand = 8'd254; mplier = 8'd253; modulus = 8'd255;
        in_valid_a = 1'b1;
        step();
        in_valid_a = 1'b0;
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_idle", 32'(ready_a), 32'd1);
        check("abort_no_valid", 32'(ovalid_a), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (ovalid_a) seen = 1'b1;
        end
        check("abort_never_valid", 32'(seen), 32'd0);
        in_valid_a = 1'b1;
        abort = 1'b1;
        step();
        in_valid_a = 1'b0;
        abort = 1'b0;
        check("abort_blocks_accept", 32'(ready_a), 32'd1);

        // Asynchronous reset mid-RUN.
        in_valid_a = 1'b1;
        step();
        in_valid_a = 1'b0;
        step();
        reset_n = 1'b0;
        #1;
        check("arst_in_ready", 32'(ready_a), 32'd1);
        check("arst_out_valid", 32'(ovalid_a), 32'd0);
        check("arst_product", 32'(prod_a), 32'd0);
        check("arst_err", 32'(err_a), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (ovalid_a) seen = 1'b1;
        end
        check("arst_result_lost", 32'(seen), 32'd0);
        run_op(0, 1'b0, 8'd7, 8'd9, 8'd13, 8'd11, 1'b0, 5, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/modmult_hs.md
MODMULT_HS -- requirements
Module: modmult_hs

Interface
REQ-001 SHALL have parameter MPWID, default 32, meaning operand/modulus width in bits (legal range >= 4).
REQ-002 SHALL have parameter EARLY_EXIT, default 1, meaning 1 = stop after the highest set multiplier bit and 0 = always run MPWID iterations (fixed latency).
REQ-003 SHALL have port clk  in  1  rising-edge clock, the only clock.
REQ-004 SHALL have port reset_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  in  1  operand set offered.
REQ-006 SHALL have port in_ready  out  1  block can accept operands.
REQ-007 SHALL have port mode  in  1  0 = multiply mpand*mplier, 1 = square mpand*mpand (mplier ignored).
REQ-008 SHALL have ports mpand, mplier and modulus  in  MPWID each  operands.
REQ-009 SHALL have port abort  in  1  synchronous cancel of the current operation.
REQ-010 SHALL have port out_valid  out  1  result available.
REQ-011 SHALL have port out_ready  in  1  consumer takes the result.
REQ-012 SHALL have port product  out  MPWID  (mpand*mplier) mod modulus.
REQ-013 SHALL have port err  out  1  operand error qualifying product, valid with out_valid.

Function
REQ-014 SHALL accept operands on a clk edge where in_valid=1, in_ready=1 and abort=0 (cycle T), registering them internally.
REQ-015 SHALL drive in_ready=1 only in state IDLE.
REQ-016 SHALL implement states IDLE, RUN and DONE, with transitions: IDLE->RUN on a valid accept; IDLE->DONE on accept with error; RUN->DONE when iterations complete; DONE->IDLE when out_ready=1; any state->IDLE on abort=1.
REQ-017 SHALL flag an error at accept if modulus < 2 or mpand >= modulus, or if mode=0 and mplier >= modulus; on error, product=0 and err=1.
REQ-018 SHALL use radix-2 right-to-left interleaving per RUN cycle: if the current multiplier bit is 1, acc <= (acc+mc) mod M; mc <= (2*mc) mod M; then shift the multiplier right by 1.
REQ-019 SHALL compute each mod-M step with one MPWID+1-bit add and a single conditional subtract of M, since both addends are < M; no intermediate overflow is permitted.
REQ-020 SHALL take N = MPWID RUN cycles when EARLY_EXIT=0; when EARLY_EXIT=1, N = (index of highest set multiplier bit)+1, and N=0 for a zero multiplier (RUN is skipped and result 0 goes straight to DONE).
REQ-021 SHALL assert out_valid in cycle T+N+1, or T+1 for an error or N=0.
REQ-022 SHALL hold out_valid high, with product and err stable, until out_ready=1; out_valid and err deassert the cycle after that handshake.
REQ-023 SHALL NOT accept a new operand set in the same cycle as the out_ready handshake; next accept is no earlier than one cycle later.
REQ-024 SHALL give abort priority over every other event: abort in any state discards the operation with no out_valid, and abort with in_valid in IDLE causes no accept.
REQ-025 SHALL ignore operand input changes after accept.

Reset
REQ-026 SHALL, on reset_n=0, asynchronously force state IDLE, in_ready=1, out_valid=0, err=0, product=0, and clear all datapath registers.
REQ-027 SHALL, on reset assertion mid-RUN or mid-DONE, lose the result with no out_valid after release.
REQ-028 SHALL, after reset release, allow accept on the first clk edge with in_valid=1.

Structure
REQ-029 SHALL place the state enum typedef and state encodings in shared package modmult_pkg.
REQ-030 SHALL instantiate sub-module mod_add (a, b, m -> (a+b) mod m, parametrised width, combinational) twice, once for accumulate and once for doubling (b=a).
REQ-031 SHALL keep all state and datapath registers in modmult_hs; target 120-400 RTL lines total.

Verification (MPWID=8 unless noted)
REQ-032 SHALL cover mode=0, mpand=7, mplier=9, modulus=13, EARLY_EXIT=1 -> product=11, err=0, out_valid at T+5.
REQ-033 SHALL cover mode=1, mpand=12, modulus=13 -> product=1; with EARLY_EXIT=0 -> out_valid at T+9.
REQ-034 SHALL cover mpand=254, mplier=253, modulus=255 -> product=2 (max-width carry path); mplier=0 -> product=0 at T+1.
REQ-035 SHALL cover mpand=13, modulus=13 -> err=1, product=0 at T+1; modulus=1 -> err=1.
REQ-036 SHALL cover out_ready held low 3 cycles -> out_valid and product stable throughout; in_valid held high during the handshake -> accept no earlier than the next cycle.
REQ-037 SHALL cover abort at T+2 -> IDLE next cycle with no out_valid; reset_n pulsed low mid-RUN -> all outputs at reset values immediately; the next operation is correct.
